flash_arb: RTL and testbench

- Arbitrates between two burst requesters for the single flash_ctrl read port.
  - Port 0 is the icache miss controller.
  - Port 1 is the data/boot loader.
- Sequences one complete burst at a time through the flash request/ack/valid handshake.
- Steers returned beats to the granted requester, with round-robin fairness between requesters and timeout protection on the flash handshake.

---
 rtl/flash_arb_pkg.sv | 14 +
 rtl/flash_arb_rr2.sv | 14 +
 rtl/flash_arb.sv | 138 +++++++++++++
 tb/tb_flash_arb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_arb_pkg.sv
// Shared widths and state encoding for the two-port flash read arbiter.
package flash_arb_pkg;

   localparam int unsigned FLASH_AW = 20;
   localparam int unsigned FLASH_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/flash_arb_rr2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes first.
module flash_arb_rr2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       winner,
   output logic       any_req
);

   always_comb begin
      any_req = |req;
      winner  = (&req) ? ~last : req[1];
   end

endmodule

// File: rtl/flash_arb.sv
// Arbitrates icache (port 0) and loader (port 1) bursts onto the single flash_ctrl read port.
module flash_arb
   import flash_arb_pkg::*;
#(
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned ACK_TO    = 64,
   parameter int unsigned BEAT_TO   = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_req,
   input  logic [FLASH_AW-1:0] m0_addr,
   output logic                m0_ack,
   output logic                m0_valid,
   output logic                m0_last,
   output logic                m0_err,
   input  logic                m1_req,
   input  logic [FLASH_AW-1:0] m1_addr,
   output logic                m1_ack,
   output logic                m1_valid,
   output logic                m1_last,
   output logic                m1_err,
   output logic [FLASH_DW-1:0] rdata,
   output logic                f_req,
   output logic [FLASH_AW-1:0] f_addr,
   input  logic                f_ack,
   input  logic                f_valid,
   input  logic [FLASH_DW-1:0] f_data,
   output logic                busy,
   output logic                grant
);

   localparam int unsigned BC_W   = $clog2(BURST_LEN);
   localparam int unsigned TO_MAX = (ACK_TO > BEAT_TO) ? ACK_TO : BEAT_TO;
   localparam int unsigned TO_W   = $clog2(TO_MAX);

   state_t              state, state_nx;
   logic                grant_nx;
   logic [FLASH_AW-1:0] addr_nx;
   logic [BC_W-1:0]     beat_cnt, beat_nx;
   logic [TO_W-1:0]     to_cnt, to_nx;
   logic                winner, any_req;
   logic                ack_c, valid_c, last_c, err_c;
   logic [FLASH_DW-1:0] rdata_c;

   flash_arb_rr2 u_rr2 (
      .req     ({m1_req, m0_req}),
      .last    (grant),
      .winner  (winner),
      .any_req (any_req)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         grant    <= 1'b1;
         f_addr   <= '0;
         beat_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         f_addr   <= addr_nx;
         beat_cnt <= beat_nx;
         to_cnt   <= to_nx;
      end
   end

   // Burst sequencing; to_cnt serves both the ack wait and the inter-beat gap.
   always_comb begin
      state_nx = state;
      grant_nx = grant;
      addr_nx  = f_addr;
      beat_nx  = beat_cnt;
      to_nx    = to_cnt;
      ack_c    = 1'b0;
      valid_c  = 1'b0;
      last_c   = 1'b0;
      err_c    = 1'b0;
      rdata_c  = '0;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               grant_nx = winner;
               addr_nx  = winner ? m1_addr : m0_addr;
               to_nx    = '0;
               state_nx = ST_REQ;
            end
         end
         ST_REQ: begin
            if (f_ack) begin
               ack_c    = 1'b1;
               beat_nx  = '0;
               to_nx    = '0;
               state_nx = ST_XFER;
            end else if (to_cnt == TO_W'(ACK_TO - 1)) begin
               err_c    = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               to_nx = to_cnt + 1'b1;
            end
         end
         ST_XFER: begin
            if (f_valid) begin
               valid_c = 1'b1;
               rdata_c = f_data;
               beat_nx = beat_cnt + 1'b1;
               to_nx   = '0;
               if (beat_cnt == BC_W'(BURST_LEN - 1)) begin
                  last_c   = 1'b1;
                  state_nx = ST_DONE;
               end
            end else if (to_cnt == TO_W'(BEAT_TO - 1)) begin
               err_c    = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               to_nx = to_cnt + 1'b1;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Steer handshake strobes to the granted requester; a reset cycle never reports an abort.
   assign m0_ack   = ack_c   & ~grant;
   assign m1_ack   = ack_c   &  grant;
   assign m0_valid = valid_c & ~grant;
   assign m1_valid = valid_c &  grant;
   assign m0_last  = last_c  & ~grant;
   assign m1_last  = last_c  &  grant;
   assign m0_err   = err_c   & ~grant & ~reset;
   assign m1_err   = err_c   &  grant & ~reset;
   assign rdata    = rdata_c;
   assign f_req    = (state == ST_REQ);
   assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_flash_arb.sv
// Randomized burst traffic against a transaction-level arbiter/flash model.
module tb_flash_arb;

   localparam int unsigned BL      = 4;
   localparam int unsigned ACK_TO  = 64;
   localparam int unsigned BEAT_TO = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m1_req;
   logic [19:0] m0_addr, m1_addr;
   logic        m0_ack, m0_valid, m0_last, m0_err;
   logic        m1_ack, m1_valid, m1_last, m1_err;
   logic [31:0] rdata;
   logic        f_req;
   logic [19:0] f_addr;
   logic        f_ack, f_valid;
   logic [31:0] f_data;
   logic        busy, grant;

   int   n_chk  = 0;
   int   n_pass = 0;
   bit   last_g;
   logic [1:0] pend;

   always #5 clk = ~clk;

   flash_arb #(.BURST_LEN(BL), .ACK_TO(ACK_TO), .BEAT_TO(BEAT_TO)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_valid(m0_valid),
      .m0_last(m0_last), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_valid(m1_valid),
      .m1_last(m1_last), .m1_err(m1_err),
      .rdata(rdata), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
      .f_valid(f_valid), .f_data(f_data), .busy(busy), .grant(grant)
   );

   wire [7:0] obs = {m1_ack, m1_valid, m1_last, m1_err, m0_ack, m0_valid, m0_last, m0_err};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   // Expected strobe nibble {ack,valid,last,err} placed on requester w.
   function automatic logic [7:0] strobes(input bit w, input logic [3:0] s);
      return w ? {s, 4'h0} : {4'h0, s};
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_reqs();
      m0_req = pend[0];
      m1_req = pend[1];
   endtask

   // One burst from the IDLE cycle through DONE (or abort). ack_dly<0: flash never acks.
   // stall_at>=0: flash goes silent before that beat.
   task automatic burst(input logic [1:0] add, input int ack_dly, input int stall_at,
                        input bit drop, input bit fixed, input logic [31:0] dbase);
      bit          w;
      bit          done_req;
      logic [19:0] a;
      int          gap;
      pend |= add;
      if (pend == 2'b00) pend = 2'b01;
      w = (pend == 2'b11) ? !last_g : pend[1];
      // IDLE: stray f_valid/f_ack must be ignored
      m0_addr = {16'($urandom), 4'h0};
      m1_addr = {16'($urandom), 4'h0};
      a       = w ? m1_addr : m0_addr;
      drive_reqs();
      f_ack   = 1'($urandom_range(0, 1));
      f_valid = 1'($urandom_range(0, 1));
      f_data  = $urandom;
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_quiet", 64'({f_req, obs, rdata}), 64'd0);
      adv();
      last_g   = w;
      done_req = 1'b0;
      // REQ: wait for ack or ack timeout
      for (int i = 0; i < int'(ACK_TO) && !done_req; i++) begin
         m0_addr = {16'($urandom), 4'h0};
         m1_addr = {16'($urandom), 4'h0};
         f_ack   = (ack_dly >= 0) && (i == ack_dly);
         f_valid = 1'($urandom_range(0, 1));
         f_data  = $urandom;
         @(negedge clk);
         if (i == 0) begin
            check("req_addr", 64'(f_addr), 64'(a));
            check("req_grant", 64'(grant), 64'(w));
         end
         if (f_ack) begin
            check("ack", 64'({f_req, obs, rdata}), 64'({1'b1, strobes(w, 4'b1000), 32'h0}));
            done_req = 1'b1;
         end else if (i == int'(ACK_TO) - 1) begin
            check("ack_timeout", 64'({f_req, obs, rdata}), 64'({1'b1, strobes(w, 4'b0001), 32'h0}));
            done_req = 1'b1;
         end else begin
            check("req_wait", 64'({f_req, obs, rdata}), 64'({1'b1, 8'h00, 32'h0}));
         end
         adv();
      end
      f_ack = 1'b0;
      if (ack_dly < 0) begin
         pend[w] = 1'b0;
         return;
      end
      // XFER
      for (int b = 0; b < int'(BL); b++) begin
         gap = (b == stall_at) ? int'(BEAT_TO) : int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            f_valid = 1'b0;
            f_ack   = 1'($urandom_range(0, 1));
            f_data  = $urandom;
            @(negedge clk);
            if (g == int'(BEAT_TO) - 1)
               check("gap_timeout", 64'({busy, obs, rdata}), 64'({1'b1, strobes(w, 4'b0001), 32'h0}));
            else
               check("gap_quiet", 64'({busy, f_req, obs, rdata}), 64'({2'b10, 8'h00, 32'h0}));
            adv();
         end
         if (b == stall_at) begin
            pend[w] = 1'b0;
            return;
         end
         if (drop && b == 1) begin
            pend[w] = 1'b0;
            drive_reqs();
         end
         f_ack   = 1'($urandom_range(0, 1));
         f_valid = 1'b1;
         f_data  = fixed ? dbase + 32'(b) : $urandom;
         @(negedge clk);
         check("beat", 64'(obs), 64'(strobes(w, {2'b01, b == int'(BL) - 1, 1'b0})));
         check("beat_rdata", 64'(rdata), 64'(f_data));
         adv();
      end
      // DONE: one quiet turnaround cycle
      pend[w] = 1'b0;
      drive_reqs();
      f_valid = 1'($urandom_range(0, 1));
      f_ack   = 1'($urandom_range(0, 1));
      f_data  = $urandom;
      @(negedge clk);
      check("done_busy", 64'(busy), 64'd1);
      check("done_quiet", 64'({f_req, obs, rdata}), 64'd0);
      adv();
   endtask

   initial begin
      reset   = 1'b1;
      m0_req  = 1'b0;  m1_req  = 1'b0;
      m0_addr = '0;    m1_addr = '0;
      f_ack   = 1'b0;  f_valid = 1'b0;  f_data = '0;
      pend    = 2'b00;
      last_g  = 1'b1;
      adv();
      adv();
      reset = 1'b0;
      @(negedge clk);
      check("rst_grant", 64'(grant), 64'd1);
      check("rst_state", 64'({busy, f_req, f_addr, obs, rdata}), 64'd0);
      adv();

      burst(2'b01, 3, -1, 1'b0, 1'b1, 32'hA0);       // single burst, fixed beats
      burst(2'b11, -1, -1, 1'b0, 1'b0, 32'h0);       // m1 ack timeout, m0 pending
      burst(2'b00, 0, -1, 1'b0, 1'b0, 32'h0);        // pending m0 granted next
      for (int k = 0; k < 4; k++)
         burst(2'b11, int'($urandom_range(0, 3)), -1, 1'b0, 1'b0, 32'h0);
      burst(2'b00, 1, 2, 1'b0, 1'b0, 32'h0);         // beat gap timeout after 2 beats
      burst(2'b01, 2, -1, 1'b1, 1'b0, 32'h0);        // dropped request still completes

      for (int k = 0; k < 40; k++) begin
         int ad, st;
         ad = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
         st = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
         burst(2'($urandom_range(0, 3)), ad, st, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
      end

      // Reset after beat 1 aborts silently
      pend = 2'b00;
      m1_req = 1'b0;
      m0_req = 1'b1;
      m0_addr = 20'h01230;
      f_valid = 1'b0;
      adv();                                   // IDLE
      f_ack = 1'b1;
      adv();                                   // REQ acked
      f_ack = 1'b0;
      for (int b = 0; b < 2; b++) begin
         f_valid = 1'b1;
         f_data  = $urandom;
         adv();
      end
      f_valid = 1'b0;
      reset   = 1'b1;
      @(negedge clk);
      check("rst_no_err", 64'({m0_err, m1_err}), 64'd0);
      adv();
      reset  = 1'b0;
      m0_req = 1'b0;
      @(negedge clk);
      check("midrst_grant", 64'(grant), 64'd1);
      check("midrst_state", 64'({busy, f_req, f_addr, obs, rdata}), 64'd0);
      adv();
      last_g = 1'b1;
      burst(2'b11, 0, -1, 1'b0, 1'b0, 32'h0);        // m0 wins first tie after reset

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
